fetch_queue: RTL and testbench



---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue interface: push side from fetch, head side to decode.
// The master modport is the fetch/decode environment and the slave modport is the queue.
interface fetch_queue_if #(
   parameter int DEPTH = 4
) ();
   localparam int CW = $clog2(DEPTH + 1);

   logic          in_valid;
   logic [63:0]   in_pc;
   logic [31:0]   in_instr;
   logic          in_ready;
   logic          flush;
   logic          out_valid;
   logic [63:0]   out_pc;
   logic [31:0]   out_instr;
   logic          out_misalign;
   logic          out_ready;
   logic [CW-1:0] count;

   modport master (
      output in_valid, in_pc, in_instr, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_misalign, count
   );

   modport slave (
      input  in_valid, in_pc, in_instr, flush, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_misalign, count
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. Head entries fall through to decode
// one cycle after the push, and a redirect (flush) discards every queued entry.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input logic          clk,
   input logic          reset,
   fetch_queue_if.slave q
);
   localparam int            PW        = $clog2(DEPTH);
   localparam int            CW        = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;

   logic [63:0]   mem_pc_r    [DEPTH];
   logic [31:0]   mem_instr_r [DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic          ready_en_r;
   logic [63:0]   last_pc_r;
   logic [31:0]   last_instr_r;

   logic          in_ready_s;
   logic          out_valid_s;
   logic          push_s;
   logic          pop_s;
   logic [63:0]   head_pc_s;
   logic [31:0]   head_instr_s;

   // Handshake qualification; in_ready never looks at out_ready, keeping decode off the fetch path.
   always_comb begin
      in_ready_s  = ready_en_r && (count_r != FULL_CNT);
      out_valid_s = (count_r != {CW{1'b0}});
      push_s      = q.in_valid && in_ready_s && !q.flush;
      pop_s       = out_valid_s && q.out_ready && !q.flush;
   end

   // Head selection: live entry when occupied, otherwise the last value handed to decode.
   always_comb begin
      head_pc_s    = last_pc_r;
      head_instr_s = last_instr_r;
      if (out_valid_s) begin
         head_pc_s    = mem_pc_r[rd_ptr_r];
         head_instr_s = mem_instr_r[rd_ptr_r];
      end else begin
         head_pc_s    = last_pc_r;
         head_instr_s = last_instr_r;
      end
   end

   // Entry storage, written at the tail on an accepted push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc_r[i]    <= 64'h0;
            mem_instr_r[i] <= 32'h0;
         end
      end else if (push_s) begin
         mem_pc_r[wr_ptr_r]    <= q.in_pc;
         mem_instr_r[wr_ptr_r] <= q.in_instr;
      end
   end

   // Pointers, occupancy and last-read head; flush outranks push and pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_r     <= {PW{1'b0}};
         wr_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         ready_en_r   <= 1'b0;
         last_pc_r    <= RESET_PC;
         last_instr_r <= NOP_INSTR;
      end else begin
         ready_en_r <= 1'b1;
         if (q.flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
               rd_ptr_r     <= rd_ptr_r + PW'(1'b1);
               last_pc_r    <= mem_pc_r[rd_ptr_r];
               last_instr_r <= mem_instr_r[rd_ptr_r];
            end
            case ({push_s, pop_s})
               2'b10:   count_r <= count_r + CW'(1'b1);
               2'b01:   count_r <= count_r - CW'(1'b1);
               default: count_r <= count_r;
            endcase
         end
      end
   end

   assign q.in_ready     = in_ready_s;
   assign q.out_valid    = out_valid_s;
   assign q.out_pc       = head_pc_s;
   assign q.out_instr    = head_instr_s;
   assign q.out_misalign = out_valid_s && (head_pc_s[1:0] != 2'b00);
   assign q.count        = count_r;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill, drain with wrap, flush, latency, misalign.
module tb_fetch_queue;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   fetch_queue_if #(.DEPTH(4)) fq_if ();

   fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (64'h0000_0000_8000_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .q     (fq_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [63:0] pc, input logic [31:0] instr);
      fq_if.in_valid = 1'b1;
      fq_if.in_pc    = pc;
      fq_if.in_instr = instr;
      step();
      fq_if.in_valid = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      fq_if.in_valid  = 1'b0;
      fq_if.in_pc     = 64'h0;
      fq_if.in_instr  = 32'h0;
      fq_if.flush     = 1'b0;
      fq_if.out_ready = 1'b0;
      repeat (2) @(negedge clk);

      // 1. reset values, then a mid-stream reset with two entries queued
      chk("rst_count", fq_if.count, 64'd0);
      chk("rst_valid", fq_if.out_valid, 64'd0);
      chk("rst_ready", fq_if.in_ready, 64'd0);
      chk("rst_pc", fq_if.out_pc, 64'h8000_0000);
      chk("rst_instr", fq_if.out_instr, 64'h13);
      chk("rst_misalign", fq_if.out_misalign, 64'd0);
      reset = 1'b1;
      step();
      chk("post_rst_ready", fq_if.in_ready, 64'd1);
      push(64'h8000_0500, 32'h0000_0500);
      push(64'h8000_0504, 32'h0000_0504);
      chk("pre_rst_count", fq_if.count, 64'd2);
      chk("pre_rst_pc", fq_if.out_pc, 64'h8000_0500);
      #1 reset = 1'b0;
      #1;
      chk("async_rst_count", fq_if.count, 64'd0);
      chk("async_rst_valid", fq_if.out_valid, 64'd0);
      chk("async_rst_ready", fq_if.in_ready, 64'd0);
      chk("async_rst_pc", fq_if.out_pc, 64'h8000_0000);
      repeat (3) step();
      chk("held_rst_ready", fq_if.in_ready, 64'd0);
      reset = 1'b1;
      step();
      chk("rel_ready", fq_if.in_ready, 64'd1);
      chk("rel_valid", fq_if.out_valid, 64'd0);
      chk("rel_pc", fq_if.out_pc, 64'h8000_0000);
      chk("rel_instr", fq_if.out_instr, 64'h13);

      // 2. fill to full, fifth push dropped
      push(64'h8000_0000, 32'h0000_0013);
      chk("fill1_count", fq_if.count, 64'd1);
      push(64'h8000_0004, 32'h0010_0093);
      push(64'h8000_0008, 32'h0020_0113);
      push(64'h8000_000C, 32'h0030_0193);
      chk("full_count", fq_if.count, 64'd4);
      chk("full_ready", fq_if.in_ready, 64'd0);
      chk("full_head", fq_if.out_pc, 64'h8000_0000);
      push(64'h8000_0010, 32'h0000_1004);
      chk("drop5_count", fq_if.count, 64'd4);
      chk("drop5_head", fq_if.out_pc, 64'h8000_0000);
      chk("drop5_instr", fq_if.out_instr, 64'h13);

      // 3. drain from full with continuous pushes; first edge is pop-only because full blocks the push
      fq_if.out_ready = 1'b1;
      for (int c = 0; c <= 12; c++) begin
         if (c >= 1 && c <= 8) begin
            fq_if.in_valid = 1'b1;
            fq_if.in_pc    = 64'h8000_0010 + 64'(4 * (c - 1));
            fq_if.in_instr = 32'h0000_1004 + 32'(c - 1);
         end else if (c == 0) begin
            fq_if.in_valid = 1'b1;
            fq_if.in_pc    = 64'h8000_0010;
            fq_if.in_instr = 32'h0000_1004;
         end else begin
            fq_if.in_valid = 1'b0;
         end
         if (c <= 11) begin
            chk($sformatf("drain_pc_%0d", c), fq_if.out_pc, 64'h8000_0000 + 64'(4 * c));
            chk($sformatf("drain_valid_%0d", c), fq_if.out_valid, 64'd1);
            if (c >= 4) begin
               chk($sformatf("drain_instr_%0d", c), fq_if.out_instr, 64'h1000 + 64'(c));
            end
         end else begin
            chk("drain_empty_valid", fq_if.out_valid, 64'd0);
            chk("drain_last_pc", fq_if.out_pc, 64'h8000_002C);
         end
         chk($sformatf("drain_count_%0d", c), fq_if.count,
             (c == 0) ? 64'd4 : (c <= 9) ? 64'd3 : (c == 10) ? 64'd2 : (c == 11) ? 64'd1 : 64'd0);
         step();
      end
      fq_if.in_valid = 1'b0;
      fq_if.out_ready = 1'b0;

      // 4. flush outranks concurrent push and pop
      push(64'h8000_0300, 32'h0000_0300);
      push(64'h8000_0304, 32'h0000_0304);
      push(64'h8000_0308, 32'h0000_0308);
      chk("pre_flush_count", fq_if.count, 64'd3);
      fq_if.flush     = 1'b1;
      fq_if.in_valid  = 1'b1;
      fq_if.in_pc     = 64'h8000_0100;
      fq_if.in_instr  = 32'h0000_0100;
      fq_if.out_ready = 1'b1;
      step();
      chk("flush_count", fq_if.count, 64'd0);
      chk("flush_valid", fq_if.out_valid, 64'd0);
      chk("flush_ready", fq_if.in_ready, 64'd1);
      step();
      chk("flush_hold_count", fq_if.count, 64'd0);
      fq_if.flush     = 1'b0;
      fq_if.out_ready = 1'b0;
      fq_if.in_pc     = 64'h8000_0200;
      fq_if.in_instr  = 32'h0000_0200;
      chk("post_flush_valid", fq_if.out_valid, 64'd0);
      step();
      fq_if.in_valid = 1'b0;
      chk("post_flush_head", fq_if.out_pc, 64'h8000_0200);
      chk("post_flush_hvalid", fq_if.out_valid, 64'd1);
      chk("post_flush_count", fq_if.count, 64'd1);
      fq_if.out_ready = 1'b1;
      step();
      chk("post_flush_drain", fq_if.count, 64'd0);

      // 5. empty-queue latency: no bypass, popped on the cycle it appears
      fq_if.in_valid = 1'b1;
      fq_if.in_pc    = 64'h8000_0040;
      fq_if.in_instr = 32'h0000_0040;
      chk("lat_push_valid", fq_if.out_valid, 64'd0);
      step();
      fq_if.in_valid = 1'b0;
      chk("lat_valid", fq_if.out_valid, 64'd1);
      chk("lat_pc", fq_if.out_pc, 64'h8000_0040);
      chk("lat_count", fq_if.count, 64'd1);
      step();
      chk("lat_drained", fq_if.count, 64'd0);
      chk("lat_empty_valid", fq_if.out_valid, 64'd0);

      // 6. misaligned head flag
      fq_if.out_ready = 1'b0;
      push(64'h8000_0042, 32'h0000_0042);
      push(64'h8000_0044, 32'h0000_0044);
      chk("mis_pc", fq_if.out_pc, 64'h8000_0042);
      chk("mis_flag", fq_if.out_misalign, 64'd1);
      fq_if.out_ready = 1'b1;
      step();
      chk("ali_pc", fq_if.out_pc, 64'h8000_0044);
      chk("ali_flag", fq_if.out_misalign, 64'd0);
      step();
      chk("mis_empty_flag", fq_if.out_misalign, 64'd0);
      chk("mis_empty_count", fq_if.count, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
